// File: rtl/lc3_program_loader.sv
// lc3_program_loader: streams an LC-3 object image (origin, count, words) into memory
// through the special write port, holding the core in reset until the load completes.
module lc3_program_loader #(
  parameter int WRITE_CYCLES = 2,
  parameter bit HOLD_AFTER_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] MARSpcIn,
  output logic [15:0] MDRSpcIn,
  output logic        ldMARSpcIn,
  output logic        cpu_reset,
  output logic [15:0] start_pc,
  output logic        busy,
  output logic        load_done,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, ORG_LO, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE} state_t;
  localparam logic [3:0] LAST_CYC = 4'(WRITE_CYCLES - 1);
  state_t state_q, state_d;
  logic [15:0] org_q, addr_q, cnt_q, mar_q, mdr_q, start_pc_q, words_q;
  logic [7:0] hi_q;
  logic [3:0] cyc_q;
  logic ld_q, cpu_reset_q, acc, last;
  assign acc  = in_valid && in_ready;
  assign last = (state_q == WRITE) && (cyc_q == LAST_CYC);
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = ORG_LO;
      ORG_LO:  if (acc) state_d = CNT_HI;
      CNT_HI:  if (acc) state_d = CNT_LO;
      CNT_LO:  if (acc) state_d = ({cnt_q[15:8], in_data} == 16'd0) ? DONE : DAT_HI;
      DAT_HI:  if (acc) state_d = DAT_LO;
      DAT_LO:  if (acc) state_d = WRITE;
      WRITE:   if (last) state_d = (cnt_q == 16'd1) ? DONE : DAT_HI;
      default: state_d = IDLE;
    endcase
  end
  // in_ready is forced low while reset is held so no byte is taken during reset
  always_comb begin
    in_ready  = !reset && (state_q != WRITE) && (state_q != DONE);
    busy      = state_q != IDLE;
    load_done = state_q == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      org_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      mar_q       <= '0;
      mdr_q       <= '0;
      ld_q        <= 1'b0;
      cyc_q       <= '0;
      start_pc_q  <= '0;
      words_q     <= '0;
      cpu_reset_q <= HOLD_AFTER_RESET;
    end else begin
      if (acc && state_q == IDLE) begin
        org_q[15:8] <= in_data;
        cpu_reset_q <= 1'b1;
        words_q     <= '0;
      end
      if (acc && state_q == ORG_LO) begin
        org_q[7:0] <= in_data;
        addr_q     <= {org_q[15:8], in_data};
      end
      if (acc && state_q == CNT_HI) cnt_q[15:8] <= in_data;
      if (acc && state_q == CNT_LO) cnt_q[7:0] <= in_data;
      if (acc && state_q == DAT_HI) hi_q <= in_data;
      if (acc && state_q == DAT_LO) begin
        mar_q <= addr_q;
        mdr_q <= {hi_q, in_data};
        ld_q  <= 1'b1;
        cyc_q <= '0;
      end
      if (state_q == WRITE) cyc_q <= cyc_q + 4'd1;
      if (last) begin
        ld_q    <= 1'b0;
        addr_q  <= addr_q + 16'd1;
        words_q <= words_q + 16'd1;
        cnt_q   <= cnt_q - 16'd1;
      end
      if (state_q == DONE) begin
        start_pc_q  <= org_q;
        cpu_reset_q <= 1'b0;
      end
    end
  assign MARSpcIn     = mar_q;
  assign MDRSpcIn     = mdr_q;
  assign ldMARSpcIn   = ld_q;
  assign cpu_reset    = cpu_reset_q;
  assign start_pc     = start_pc_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_lc3_program_loader.sv
// tb_lc3_program_loader: scoreboard bench; stimulus queues expected writes/loads,
// a negedge monitor pops and compares whenever the DUT strobes or finishes a load.
module tb_lc3_program_loader;
  localparam int WC = 3;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, ldMARSpcIn, cpu_reset, busy, load_done;
  logic [15:0] MARSpcIn, MDRSpcIn, start_pc, words_loaded, exp_org;
  int tests = 0, fails = 0, acc_cnt = 0, run = 0, rdy_low = 0, acc0;
  bit ld_prev = 0, skip_len = 0, done_pend = 0;
  logic [31:0] wq[$], dq[$], cur_w, cur_d;
  logic [7:0] img[$];
  always #5 clk = ~clk;
  lc3_program_loader #(.WRITE_CYCLES(WC), .HOLD_AFTER_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .MARSpcIn(MARSpcIn), .MDRSpcIn(MDRSpcIn), .ldMARSpcIn(ldMARSpcIn), .cpu_reset(cpu_reset),
    .start_pc(start_pc), .busy(busy), .load_done(load_done), .words_loaded(words_loaded));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic miss(input string n);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", n);
  endtask
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (ldMARSpcIn) begin
      if (!ld_prev) begin
        if (wq.size() == 0) miss("unexpected_write");
        else begin
          cur_w = wq.pop_front();
          chk("write", {MARSpcIn, MDRSpcIn}, cur_w);
        end
        run = 0;
        rdy_low = 0;
      end else chk("write_stable", {MARSpcIn, MDRSpcIn}, cur_w);
      run++;
      if (!in_ready) rdy_low++;
    end else if (ld_prev) begin
      if (!skip_len) begin
        chk("strobe_len", run, WC);
        chk("ready_low_len", rdy_low, WC);
      end
      skip_len = 0;
    end
    ld_prev = ldMARSpcIn;
    if (done_pend) begin
      chk("start_pc", start_pc, exp_org);
      chk("cpu_reset_after_done", cpu_reset, 0);
      done_pend = 0;
    end
    if (load_done) begin
      if (dq.size() == 0) miss("unexpected_done");
      else begin
        cur_d = dq.pop_front();
        chk("words_loaded", words_loaded, cur_d[15:0]);
        exp_org = cur_d[31:16];
        done_pend = 1;
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    bit r;
    int t = 0;
    in_valid = 1;
    in_data = b;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!r && t < 100);
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept expected accept of %h", b);
    end
  endtask
  task automatic send_img(input logic [7:0] q[$], input int gmax);
    int g;
    foreach (q[i]) begin
      send_byte(q[i]);
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      if (g > 0) begin
        in_valid = 0;
        repeat (g) @(posedge clk);
        #1;
      end
    end
    in_valid = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld", ldMARSpcIn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_pc_words", {start_pc, words_loaded}, 0);
    chk("rst_mar_mdr", {MARSpcIn, MDRSpcIn}, 0);
    chk("rst_done", load_done, 0);
    reset = 0;
    @(posedge clk);
    #1;
    wq.push_back(32'h3000_1234); wq.push_back(32'h3001_ABCD); dq.push_back(32'h3000_0002);
    img = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_img(img, 0);
    wait_idle();
    dq.push_back(32'h4000_0000);
    send_byte(8'h40);
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_start_pc_held", start_pc, 16'h3000);
    chk("reload_no_done", load_done, 0);
    chk("reload_busy", busy, 1);
    img = '{8'h00, 8'h00, 8'h00};
    send_img(img, 0);
    chk("zero_done_timing", load_done, 1);
    wait_idle();
    wq.push_back(32'hFFFF_0001); wq.push_back(32'h0000_0002); dq.push_back(32'hFFFF_0002);
    img = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
    send_img(img, 0);
    wait_idle();
    acc0 = acc_cnt;
    wq.push_back(32'h5000_DEAD); wq.push_back(32'h5001_BEEF); wq.push_back(32'h5002_0123);
    dq.push_back(32'h5000_0003);
    img = '{8'h50, 8'h00, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23};
    send_img(img, 0);
    wait_idle();
    chk("accepted_bytes", acc_cnt - acc0, 10);
    wq.push_back(32'h6010_CAFE); wq.push_back(32'h6011_F00D); dq.push_back(32'h6010_0002);
    img = '{8'h60, 8'h10, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_img(img, 4);
    wait_idle();
    wq.push_back(32'h3000_1111);
    img = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h11, 8'h11};
    send_img(img, 0);
    @(posedge clk);
    #2;
    skip_len = 1;
    reset = 1;
    #1;
    chk("abort_ld", ldMARSpcIn, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cpu_reset", cpu_reset, 1);
    @(posedge clk);
    #1;
    reset = 0;
    wq.push_back(32'h3000_1234); wq.push_back(32'h3001_ABCD); dq.push_back(32'h3000_0002);
    img = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_img(img, 0);
    wait_idle();
    chk("writes_left", wq.size(), 0);
    chk("loads_left", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
